// File: rtl/aes256_decrypt_iter.sv
// Iterative AES-256 decryption: one key-schedule step or one inverse round per clock.
// Define AES256_KEY_CACHE_EN to keep the last expanded key and skip key expansion on a repeated key.
module aes256_decrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher,
  input  logic [255:0] key,
  output logic [127:0] plain,
  output logic         done,
  output logic         ready,
  output logic         busy,
  output logic [2:0]   dbg_state
);

  // Handshake: a block is accepted on a rising edge where start && ready; start while busy is
  // ignored. Each accepted block produces exactly one done pulse, unless rst aborts it first.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYEXP = 3'd1,
    S_LOAD   = 3'd2,
    S_ROUND  = 3'd3,
    S_FINAL  = 3'd4
  } state_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xt(aa);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(gmul(a3, a3), gmul(a3, a3));
    a15  = gmul(a12, a3);
    a240 = gmul(a15, a15);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int s);
    logic [15:0] d;
    d = {a, a} << s;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte i of the block sits at [127-8i -: 8]; column c holds bytes 4c..4c+3, row r is byte 4c+r.
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] plain_q, plain_d;
  logic         done_q, done_d;
  logic [127:0] cipher_q;
  logic [127:0] rk_q [15];
  logic         key_load, rk_we;
  logic         cache_hit;
  logic [127:0] kx_prev1, kx_prev2, kx_new;
  logic [31:0]  kx_t, kx_w0, kx_w1, kx_w2, kx_w3;
  logic [127:0] inv_core, round_out;

`ifdef AES256_KEY_CACHE_EN
  logic         cache_vld_q, cache_vld_d;
  logic [255:0] cache_key_q, cache_key_d;
  assign cache_hit = cache_vld_q && (key == cache_key_q);
`else
  assign cache_hit = 1'b0;
`endif

  // Round key k is built from keys k-1 and k-2; even k gets RotWord+SubWord+Rcon, odd k SubWord.
  always_comb begin
    kx_prev1 = rk_q[rnd_q - 4'd1];
    kx_prev2 = rk_q[rnd_q - 4'd2];
    if (!rnd_q[0]) kx_t = sub_word({kx_prev1[23:0], kx_prev1[31:24]}) ^ {rcon_q, 24'h000000};
    else           kx_t = sub_word(kx_prev1[31:0]);
    kx_w0  = kx_prev2[127:96] ^ kx_t;
    kx_w1  = kx_prev2[95:64]  ^ kx_w0;
    kx_w2  = kx_prev2[63:32]  ^ kx_w1;
    kx_w3  = kx_prev2[31:0]   ^ kx_w2;
    kx_new = {kx_w0, kx_w1, kx_w2, kx_w3};
  end

  assign inv_core  = inv_shift_sub(blk_q);
  assign round_out = inv_mix(inv_core ^ rk_q[rnd_q]);

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    rcon_d   = rcon_q;
    blk_d    = blk_q;
    plain_d  = plain_q;
    done_d   = 1'b0;
    key_load = 1'b0;
    rk_we    = 1'b0;
`ifdef AES256_KEY_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_key_d = cache_key_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_load = 1'b1;
          rcon_d   = 8'h01;
          if (cache_hit) begin
            state_d = S_LOAD;
            rnd_d   = 4'd13;
          end else begin
            state_d = S_KEYEXP;
            rnd_d   = 4'd2;
`ifdef AES256_KEY_CACHE_EN
            cache_vld_d = 1'b0;
            cache_key_d = key;
`endif
          end
        end
      end
      S_KEYEXP: begin
        rk_we = 1'b1;
        if (!rnd_q[0]) rcon_d = xt(rcon_q);
        if (rnd_q == 4'd14) begin
          state_d = S_LOAD;
          rnd_d   = 4'd13;
`ifdef AES256_KEY_CACHE_EN
          cache_vld_d = 1'b1;
`endif
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_LOAD: begin
        blk_d   = cipher_q ^ rk_q[14];
        state_d = S_ROUND;
      end
      S_ROUND: begin
        blk_d = round_out;
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) state_d = S_FINAL;
      end
      S_FINAL: begin
        plain_d = inv_core ^ rk_q[0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      rcon_q  <= 8'h01;
      blk_q   <= '0;
      plain_q <= '0;
      done_q  <= 1'b0;
`ifdef AES256_KEY_CACHE_EN
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      rcon_q  <= rcon_d;
      blk_q   <= blk_d;
      plain_q <= plain_d;
      done_q  <= done_d;
`ifdef AES256_KEY_CACHE_EN
      cache_vld_q <= cache_vld_d;
      cache_key_q <= cache_key_d;
`endif
    end
  end

  // Round-key file and captured ciphertext carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (key_load) begin
      rk_q[0]  <= key[255:128];
      rk_q[1]  <= key[127:0];
      cipher_q <= cipher;
    end
    if (rk_we) rk_q[rnd_q] <= kx_new;
  end

  assign plain     = plain_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign ready     = (state_q == S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_aes256_decrypt_iter.sv
// Bench for aes256_decrypt_iter: known-answer vectors plus random blocks produced by a forward
// AES-256 model, so the core must invert them. Honours AES256_KEY_CACHE_EN for expected latency.
module tb_aes256_decrypt_iter;

  localparam logic [255:0] K_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] P_C3 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K_SP = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] C_SP = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] P_SP = 128'h6bc1bee22e409f96e93d7e117393172a;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] cipher;
  logic [255:0] key;
  logic [127:0] plain;
  logic         done, ready, busy;
  logic [2:0]   dbg_state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   sbox_t [256];
`ifdef AES256_KEY_CACHE_EN
  bit           mc_vld = 1'b0;
  logic [255:0] mc_key = '0;
`endif

  aes256_decrypt_iter dut (
    .clk(clk), .rst(rst), .start(start), .cipher(cipher), .key(key),
    .plain(plain), .done(done), .ready(ready), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
    logic [15:0] d;
    d = {x, x} << s;
    return d[15:8];
  endfunction

  function automatic logic [7:0] xt8(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box table from the generator-3 walk over GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Forward AES-256 over a byte array; the core under test must undo it.
  function automatic logic [127:0] aes_enc(input logic [255:0] k, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h000000};
        rc  = xt8(rc);
      end else if (i % 8 == 4) begin
        tmp = sub_w(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8];
    for (int r = 0; r <= 14; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) s[4*c + row] = t[4*((c + row) % 4) + row];
        if (r < 14) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = xt8(a0) ^ xt8(a1) ^ a1 ^ a2 ^ a3;
            s[4*c+1] = a0 ^ xt8(a1) ^ xt8(a2) ^ a2 ^ a3;
            s[4*c+2] = a0 ^ a1 ^ xt8(a2) ^ xt8(a3) ^ a3;
            s[4*c+3] = xt8(a0) ^ a0 ^ a1 ^ a2 ^ xt8(a3);
          end
        end
      end
      for (int i = 0; i < 16; i++) begin
        tmp  = w[4*r + i/4];
        s[i] = s[i] ^ tmp[31 - 8*(i%4) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expected accept-to-done latency; with the key cache a repeated key skips key expansion.
  task automatic model_accept(input logic [255:0] k, output int lat);
`ifdef AES256_KEY_CACHE_EN
    lat    = (mc_vld && k == mc_key) ? 15 : 28;
    mc_vld = 1'b1;
    mc_key = k;
`else
    lat = 28;
`endif
  endtask

  task automatic model_reset();
`ifdef AES256_KEY_CACHE_EN
    mc_vld = 1'b0;
`endif
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check_val("ready_timeout", 128'(ready), 128'd1);
  endtask

  task automatic idle_watch(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  // One block: n counts edges after the accepting edge, so done seen at n == latency.
  task automatic run_op(input logic [255:0] k, input logic [127:0] c, input logic [127:0] p,
                        input bit disturb, input string tag);
    int n, lat;
    logic [127:0] exp_p;
    wait_ready();
    key    = k;
    cipher = c;
    start  = 1'b1;
    model_accept(k, lat);
    exp_q.push_back(p);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (disturb) begin
        if (n == 3) cipher = rand128();
        if (n == 5) start = 1'b1;
        if (n == 6) start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    exp_p = exp_q.pop_front();
    check_val({tag, "_latency"}, 128'(n), 128'(lat));
    check_val({tag, "_plain"}, plain, exp_p);
    check_val({tag, "_ready_at_done"}, 128'(ready), 128'd1);
    check_val({tag, "_busy_at_done"}, 128'(busy), 128'd0);
    @(negedge clk);
    check_val({tag, "_done_single"}, 128'(done), 128'd0);
    check_val({tag, "_plain_hold"}, plain, exp_p);
  endtask

  initial begin
    int n, lat1, lat2, t1, t2, cnt, dcnt;
    logic [255:0] k;
    logic [127:0] p, p2;

    build_sbox();
    rst = 1'b1; start = 1'b0; cipher = '0; key = '0;
    repeat (3) @(negedge clk);
    check_val("rst_plain", plain, 128'd0);
    check_val("rst_done", 128'(done), 128'd0);
    check_val("rst_busy", 128'(busy), 128'd0);
    check_val("rst_ready", 128'(ready), 128'd1);
    rst = 1'b0;

    run_op(K_C3, C_C3, P_C3, 1'b0, "fips_c3");
    run_op(K_SP, C_SP, P_SP, 1'b0, "sp800_38a");

    for (int i = 0; i < 6; i++) begin
      k  = {rand128(), rand128()};
      p  = rand128();
      p2 = rand128();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(k, aes_enc(k, p), p, 1'b0, "rand");
      if (i % 2 == 0) run_op(k, aes_enc(k, p2), p2, 1'b0, "rand_same_key");
    end

    run_op(K_C3, C_C3, P_C3, 1'b1, "disturb");
    idle_watch(35, cnt);
    check_val("disturb_extra_done", 128'(cnt), 128'd0);

    wait_ready();
    key = K_C3; cipher = C_C3; start = 1'b1;
    model_accept(K_C3, lat1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0; dcnt = 0;
    while (n < 17) begin
      @(negedge clk);
      n++;
      if (done) dcnt++;
    end
    rst = 1'b1;
    #1;
    model_reset();
    check_val("abort_plain", plain, 128'd0);
    check_val("abort_busy", 128'(busy), 128'd0);
    check_val("abort_ready", 128'(ready), 128'd1);
    check_val("abort_done", 128'(done), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_watch(40, cnt);
    check_val("abort_no_done", 128'(cnt + dcnt), 128'd0);
    run_op(K_C3, C_C3, P_C3, 1'b0, "post_abort");

    wait_ready();
    key = K_C3; cipher = C_C3; start = 1'b1;
    model_accept(K_C3, lat1);
    lat2 = 0;
    @(posedge clk);
    @(negedge clk);
    n = 0; t1 = -1; t2 = -1;
    while (n < 100 && t2 < 0) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (t1 < 0) begin
          t1 = n;
          check_val("b2b_plain_first", plain, P_C3);
          model_accept(K_C3, lat2);
        end else begin
          t2 = n;
          start = 1'b0;
          check_val("b2b_plain_second", plain, P_C3);
        end
      end
    end
    start = 1'b0;
    check_val("b2b_first_latency", 128'(t1), 128'(lat1));
    check_val("b2b_done_spacing", 128'(t2 - t1), 128'(lat2 + 1));

    run_op(K_C3, C_C3, P_C3, 1'b0, "key_repeat_a");
    run_op(K_C3, C_C3, P_C3, 1'b0, "key_repeat_b");
    run_op(K_SP, C_SP, P_SP, 1'b0, "key_change");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
